// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate strobe, H/V counters, and sync/blank
// outputs delayed by PIPE_DLY strobes to line up with the cell/font fetch stage.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_DLY = 3,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dispEnable,
  output logic        pixStrobe,
  output logic [11:0] pixPosX,
  output logic [11:0] pixPosY,
  output logic        pixLineOdd,
  output logic        pixActive,
  output logic        hsyncOut,
  output logic        vsyncOut,
  output logic        blankOut,
  output logic        frameStart,
  output logic [15:0] frameCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DLY_N   = (PIPE_DLY == 0) ? 1 : PIPE_DLY;
  localparam int LAST    = (PIPE_DLY == 0) ? 0 : PIPE_DLY - 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line entries are {hs, vs, blank}, active-high; idle = no sync, blanked.
  localparam logic [2:0] IDLE = 3'b001;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [11:0]      h_cnt_q, h_cnt_d;
  logic [11:0]      v_cnt_q, v_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             strobe_q, strobe_d;
  logic             frame_start_q, frame_start_d;
  logic             active_q, active_d;
  logic [2:0]       out_q, out_d;
  logic [2:0]       dly_q [DLY_N];
  logic [2:0]       dly_d [DLY_N];
  logic [2:0]       raw;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;

  assign tick   = (div_cnt_q == DIV_LAST);
  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    strobe_d      = 1'b0;
    frame_start_d = 1'b0;
    active_d      = active_q;
    out_d         = out_q;
    raw           = IDLE;
    for (int i = 0; i < DLY_N; i++) dly_d[i] = dly_q[i];

    if (!dispEnable) begin
      // Disable aborts the frame outright; only the frame counter survives.
      div_cnt_d = '0;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      active_d  = 1'b0;
      out_d     = IDLE;
      for (int i = 0; i < DLY_N; i++) dly_d[i] = IDLE;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_ONE;
      if (tick) begin
        strobe_d = 1'b1;
        h_cnt_d  = h_wrap ? '0 : h_cnt_q + 12'd1;
        if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 12'd1;
        if (h_wrap && v_wrap) begin
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 16'd1;
        end
        // Flags are computed from the next counts so they align with pixPosX/Y.
        active_d = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
        raw = {(h_cnt_d >= HS_START) && (h_cnt_d < HS_END),
               (v_cnt_d >= VS_START) && (v_cnt_d < VS_END),
               !active_d};
        out_d    = (PIPE_DLY == 0) ? raw : dly_q[LAST];
        dly_d[0] = raw;
        for (int i = 1; i < DLY_N; i++) dly_d[i] = dly_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      strobe_q      <= 1'b0;
      frame_start_q <= 1'b0;
      active_q      <= 1'b0;
      out_q         <= IDLE;
      for (int i = 0; i < DLY_N; i++) dly_q[i] <= IDLE;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      strobe_q      <= strobe_d;
      frame_start_q <= frame_start_d;
      active_q      <= active_d;
      out_q         <= out_d;
      for (int i = 0; i < DLY_N; i++) dly_q[i] <= dly_d[i];
    end
  end

  assign pixStrobe  = strobe_q;
  assign pixPosX    = h_cnt_q;
  assign pixPosY    = v_cnt_q;
  assign pixLineOdd = v_cnt_q[0];
  assign pixActive  = active_q;
  assign hsyncOut   = out_q[2] ? HS_POL : ~HS_POL;
  assign vsyncOut   = out_q[1] ? VS_POL : ~VS_POL;
  assign blankOut   = out_q[0];
  assign frameStart = frame_start_q;
  assign frameCount = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small raster (15x8), a CLK_DIV=1 instance,
// and a 1x1 raster instance used to walk the frame counter through its wrap.
module tb_vga_timing_gen;

  localparam int HS_S  = 10;
  localparam int HS_E  = 13;
  localparam int VS_S  = 5;
  localparam int VS_E  = 7;
  localparam int FRAME = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en_a, en_b, en_c;

  logic        a_strobe, a_odd, a_act, a_hs, a_vs, a_blank, a_fs;
  logic [11:0] a_x, a_y;
  logic [15:0] a_fc;
  logic        b_strobe, b_odd, b_act, b_hs, b_vs, b_blank, b_fs;
  logic [11:0] b_x, b_y;
  logic [15:0] b_fc;
  logic        c_strobe, c_odd, c_act, c_hs, c_vs, c_blank, c_fs;
  logic [11:0] c_x, c_y;
  logic [15:0] c_fc;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .PIPE_DLY(3), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (
    .clock(clk), .reset(reset), .dispEnable(en_a),
    .pixStrobe(a_strobe), .pixPosX(a_x), .pixPosY(a_y), .pixLineOdd(a_odd),
    .pixActive(a_act), .hsyncOut(a_hs), .vsyncOut(a_vs), .blankOut(a_blank),
    .frameStart(a_fs), .frameCount(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .PIPE_DLY(0), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .clock(clk), .reset(reset), .dispEnable(en_b),
    .pixStrobe(b_strobe), .pixPosX(b_x), .pixPosY(b_y), .pixLineOdd(b_odd),
    .pixActive(b_act), .hsyncOut(b_hs), .vsyncOut(b_vs), .blankOut(b_blank),
    .frameStart(b_fs), .frameCount(b_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
    .CLK_DIV(1), .PIPE_DLY(0), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_c (
    .clock(clk), .reset(reset), .dispEnable(en_c),
    .pixStrobe(c_strobe), .pixPosX(c_x), .pixPosY(c_y), .pixLineOdd(c_odd),
    .pixActive(c_act), .hsyncOut(c_hs), .vsyncOut(c_vs), .blankOut(c_blank),
    .frameStart(c_fs), .frameCount(c_fc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int c_en     = 0;
  int fc_base  = 0;
  int fs_seen  = 0;
  int last_fs  = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic hs_of(input int x);
    return (x >= HS_S) && (x < HS_E);
  endfunction

  function automatic logic vs_of(input int y);
    return (y >= VS_S) && (y < VS_E);
  endfunction

  function automatic logic act_of(input int x, input int y);
    return (x < 8) && (y < 4);
  endfunction

  // Instance A: k strobes after enable the raster sits at k mod 15 / (k/15) mod 8,
  // and sync/blank show the position from 3 strobes earlier (idle before strobe 4).
  task automatic run_a(input int n);
    int k, x, y, kd, dx, dy;
    logic e_hs, e_vs, e_bl, e_fs, e_act;
    for (int i = 0; i < n; i++) begin
      step();
      c_en++;
      k = c_en / 2;
      x = k % 15;
      y = (k / 15) % 8;
      e_act = (k > 0) && act_of(x, y);
      if (k - 3 >= 1) begin
        kd = k - 3;
        dx = kd % 15;
        dy = (kd / 15) % 8;
        e_hs = hs_of(dx);
        e_vs = vs_of(dy);
        e_bl = !act_of(dx, dy);
      end else begin
        e_hs = 1'b0;
        e_vs = 1'b0;
        e_bl = 1'b1;
      end
      e_fs = (c_en % 2 == 0) && (k > 0) && (k % FRAME == 0);
      check("a_strobe", a_strobe, (c_en % 2 == 0));
      check("a_x", a_x, x);
      check("a_y", a_y, y);
      check("a_odd", a_odd, y % 2);
      check("a_active", a_act, e_act);
      check("a_hsync", a_hs, !e_hs);
      check("a_vsync", a_vs, !e_vs);
      check("a_blank", a_blank, e_bl);
      check("a_fstart", a_fs, e_fs);
      check("a_fcount", a_fc, 16'(fc_base + k / FRAME));
      if (a_fs) begin
        if (last_fs >= 0) check("a_fs_gap", c_en - last_fs, 240);
        last_fs = c_en;
        fs_seen++;
      end
    end
  endtask

  task automatic check_a_idle(input string tag, input int exp_fc);
    check({tag, "_strobe"}, a_strobe, 0);
    check({tag, "_x"}, a_x, 0);
    check({tag, "_y"}, a_y, 0);
    check({tag, "_active"}, a_act, 0);
    check({tag, "_hsync"}, a_hs, 1);
    check({tag, "_vsync"}, a_vs, 1);
    check({tag, "_blank"}, a_blank, 1);
    check({tag, "_fstart"}, a_fs, 0);
    check({tag, "_fcount"}, a_fc, exp_fc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    en_c  = 1'b0;
    repeat (3) step();
    check_a_idle("rst", 0);

    // Three full frames, then stop at X=5, Y=2 of the fourth frame.
    reset = 1'b1;
    en_a  = 1'b1;
    run_a(790);
    check("fs_count_3", fs_seen, 3);
    check("abort_x", a_x, 5);
    check("abort_y", a_y, 2);

    en_a = 1'b0;
    step();
    check_a_idle("dis", 3);
    repeat (3) step();
    check_a_idle("dis_hold", 3);

    // Re-enable: first frameStart only after a full 120-strobe frame.
    en_a    = 1'b1;
    c_en    = 0;
    fc_base = 3;
    last_fs = -1;
    run_a(250);
    check("fs_count_4", fs_seen, 4);
    check("fcount_4", a_fc, 4);

    // Reset mid-frame while enabled.
    run_a(30);
    reset = 1'b0;
    step();
    check_a_idle("midrst", 0);
    reset   = 1'b1;
    c_en    = 0;
    fc_base = 0;
    last_fs = -1;
    run_a(300);

    // CLK_DIV = 1, PIPE_DLY = 0: strobe every clock, sync follows position directly.
    check("b_strobe_off", b_strobe, 0);
    en_b = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      check("b_strobe", b_strobe, 1);
      check("b_x", b_x, j % 15);
      check("b_y", b_y, (j / 15) % 8);
      check("b_hsync", b_hs, !hs_of(j % 15));
      check("b_blank", b_blank, !act_of(j % 15, (j / 15) % 8));
    end
    en_b = 1'b0;

    // 1x1 raster: every enabled clock is a frame, so 65535 clocks reach 0xFFFF.
    check("c_fcount_init", c_fc, 0);
    en_c = 1'b1;
    repeat (65535) step();
    check("c_fcount_ffff", c_fc, 16'hFFFF);
    check("c_fstart_ffff", c_fs, 1);
    step();
    check("c_fcount_wrap", c_fc, 16'h0000);
    check("c_fstart_wrap", c_fs, 1);
    en_c = 1'b0;
    step();
    check("c_fcount_held", c_fc, 16'h0000);
    check("c_fstart_off", c_fs, 0);
    check("c_strobe_off", c_strobe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
